// File: rtl/sram_1r1w_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_1r1w_ctrl
// Description : Host-side controller for a 1R1W OpenRAM macro. It clears the
//               array after reset and presents valid/ready write and read
//               channels. Same-cycle write->read hits are forwarded
//               write-first, and read data is buffered in a small response
//               FIFO with credit-based read acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1r1w_ctrl #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    RSP_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int                    c_PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int                    c_CNT_W     = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;
  localparam logic [c_PTR_W-1:0]    c_LAST_PTR  = c_PTR_W'(RSP_DEPTH - 1);
  localparam logic [c_CNT_W:0]      c_DEPTH     = (c_CNT_W + 1)'(RSP_DEPTH);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_sweep;
  logic [ADDR_WIDTH-1:0] w_sweep_nxt;

  logic                  r_inflight;
  logic                  r_fwd;
  logic [DATA_WIDTH-1:0] r_fwd_data;

  logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic                  w_run;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_fwd_hit;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [c_CNT_W:0]      w_used;

  assign w_run    = (r_state == ST_RUN);
  assign w_wr_acc = wr_valid && w_run;

  // Credits: buffered words plus the read whose data arrives this cycle.
  // Depends only on registered state, never on rsp_ready.
  assign w_used   = {1'b0, r_count} + (c_CNT_W + 1)'(r_inflight);
  assign rd_ready = w_run && (w_used < c_DEPTH);
  assign w_rd_acc = rd_valid && rd_ready;

  assign sram_csb1  = !w_rd_acc;
  assign sram_addr1 = rst_n ? rd_addr : '0;

  // A same-cycle write to the read address wins over the stale macro output.
  assign w_fwd_hit   = w_wr_acc && w_rd_acc && (wr_addr == rd_addr);
  assign w_push      = r_inflight;
  assign w_push_data = r_fwd ? r_fwd_data : sram_dout1;

  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? r_fifo[r_rd_ptr] : '0;

  // State register and clear-sweep address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

  // Next state and write-port drive: sweep during INIT, host writes in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    wr_ready    = 1'b0;
    init_done   = 1'b0;
    sram_csb0   = 1'b1;
    sram_addr0  = '0;
    sram_din0   = '0;
    case (r_state)
      ST_INIT: begin
        // Keep the macro deselected while reset is held.
        if (rst_n) begin
          sram_csb0  = 1'b0;
          sram_addr0 = r_sweep;
          sram_din0  = INIT_VALUE;
        end
        w_sweep_nxt = r_sweep + 1'b1;
        if (r_sweep == c_LAST_ADDR) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        init_done  = 1'b1;
        wr_ready   = 1'b1;
        sram_csb0  = !w_wr_acc;
        sram_addr0 = wr_addr;
        sram_din0  = wr_data;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Track the read whose data is due next cycle and any forwarded word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_inflight <= w_rd_acc;
      r_fwd      <= w_fwd_hit;
      if (w_fwd_hit) begin
        r_fwd_data <= wr_data;
      end
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Response FIFO storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_push_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_1r1w_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_1r1w_ctrl
// Description : Self-checking bench for sram_1r1w_ctrl with a behavioural
//               macro and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_1r1w_ctrl;

  localparam int DW     = 16;
  localparam int AW     = 8;
  localparam int DEPTH  = 3;
  localparam int NWORDS = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic          rsp_valid, rsp_ready, init_done, sram_csb0, sram_csb1;
  logic [AW-1:0] wr_addr, rd_addr, sram_addr0, sram_addr1;
  logic [DW-1:0] wr_data, rsp_data, sram_din0, sram_dout1;

  always #5 clk = ~clk;

  sram_1r1w_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .INIT_VALUE(16'h0000),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .init_done (init_done),
    .sram_csb0 (sram_csb0),
    .sram_addr0(sram_addr0),
    .sram_din0 (sram_din0),
    .sram_csb1 (sram_csb1),
    .sram_addr1(sram_addr1),
    .sram_dout1(sram_dout1)
  );

  // Behavioural 1R1W macro: a colliding read returns the old word.
  logic [DW-1:0] macro_mem [NWORDS];
  always @(posedge clk) begin
    if (!sram_csb0) macro_mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= macro_mem[sram_addr1];
  end

  // Reference model: array contents plus queue of outstanding reads.
  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } rsp_t;

  logic [DW-1:0] ref_mem [NWORDS];
  rsp_t          q[$];
  int            cyc = 0;
  int            since_rst = 0;
  int            n_vec = 0;
  int            n_fail = 0;

  logic          s_rd_ready, s_rsp_valid;
  logic [DW-1:0] s_rsp_data;

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rv;
    logic [AW-1:0] ra;
    logic          rr;
    logic          e_rdy;
    logic          e_vld;
    logic [DW-1:0] e_dat;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0;
  endtask

  // One clock cycle: check outputs at negedge, update model at posedge.
  task automatic step();
    logic          acc_w, acc_r, pop, run, exp_v, exp_rdy;
    logic [DW-1:0] exp_d;
    exp_d = '0;
    @(negedge clk);
    s_rd_ready  = rd_ready;
    s_rsp_valid = rsp_valid;
    s_rsp_data  = rsp_data;
    run = (since_rst >= NWORDS);
    chk("wr_ready", 32'(wr_ready), 32'(run));
    chk("init_done", 32'(init_done), 32'(run));
    if (!run) begin
      chk("sweep_csb0", 32'(sram_csb0), 32'(0));
      chk("sweep_addr0", 32'(sram_addr0), 32'(since_rst));
      chk("sweep_din0", 32'(sram_din0), 32'(0));
      chk("init_rd_ready", 32'(rd_ready), 32'(0));
      chk("init_rsp_valid", 32'(rsp_valid), 32'(0));
    end else begin
      exp_rdy = (q.size() < DEPTH);
      chk("rd_ready", 32'(rd_ready), 32'(exp_rdy));
      chk("csb0", 32'(sram_csb0), 32'(!wr_valid));
      if (wr_valid) begin
        chk("addr0", 32'(sram_addr0), 32'(wr_addr));
        chk("din0", 32'(sram_din0), 32'(wr_data));
      end
      chk("csb1", 32'(sram_csb1), 32'(!(rd_valid && exp_rdy)));
      if (rd_valid && exp_rdy) chk("addr1", 32'(sram_addr1), 32'(rd_addr));
      exp_v = (q.size() > 0) && (q[0].acc <= cyc - 2);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
    end
    acc_w = wr_valid && wr_ready;
    acc_r = rd_valid && rd_ready;
    pop   = rsp_valid && rsp_ready;
    if (acc_r) exp_d = (acc_w && (wr_addr == rd_addr)) ? wr_data : ref_mem[rd_addr];
    @(posedge clk);
    if (pop && (q.size() > 0)) void'(q.pop_front());
    if (acc_r) q.push_back('{exp_d, cyc});
    if (acc_w) ref_mem[wr_addr] = wr_data;
    cyc++;
    since_rst++;
    #1;
  endtask

  // Assert reset asynchronously, check outputs at once, release after a hold.
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_csb0", 32'(sram_csb0), 32'(1));
    chk("rst_csb1", 32'(sram_csb1), 32'(1));
    chk("rst_addr0", 32'(sram_addr0), 32'(0));
    chk("rst_addr1", 32'(sram_addr1), 32'(0));
    chk("rst_din0", 32'(sram_din0), 32'(0));
    chk("rst_wr_ready", 32'(wr_ready), 32'(0));
    chk("rst_rd_ready", 32'(rd_ready), 32'(0));
    chk("rst_init_done", 32'(init_done), 32'(0));
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    since_rst = 0;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v_seen [11];

    //            wv    wa     wd        rv    ra     rr    rdy   vld   data
    tbl[0]  = '{1'b1, 8'h10, 16'h1234, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h1234};
    tbl[4]  = '{1'b1, 8'h20, 16'hBEEF, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h20, 1'b1, 1'b1, 1'b1, 16'hBEEF};
    tbl[7]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'hBEEF};
    tbl[9]  = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[11] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 16'h1234};
    tbl[12] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[13] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[14] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h1234};
    tbl[15] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'hBEEF};
    tbl[16] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h1234};
    tbl[17] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000};

    idle_inputs();
    rsp_ready = 1'b1;

    // Power-on reset, full clear sweep, then read back every address.
    do_reset(3);
    repeat (NWORDS) step();
    for (int i = 0; i < NWORDS; i++) begin
      rd_valid = 1'b1;
      rd_addr  = AW'(i);
      step();
      chk("sweep_rd_ready", 32'(s_rd_ready), 32'(1));
    end
    idle_inputs();
    repeat (4) step();
    chk("sweep_drained", 32'(q.size()), 32'(0));

    // Directed table: latency, forwarding, backpressure and drain.
    foreach (tbl[i]) begin
      wr_valid  = tbl[i].wv;
      wr_addr   = tbl[i].wa;
      wr_data   = tbl[i].wd;
      rd_valid  = tbl[i].rv;
      rd_addr   = tbl[i].ra;
      rsp_ready = tbl[i].rr;
      step();
      chk($sformatf("vec%0d_rd_ready", i), 32'(s_rd_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_rsp_valid", i), 32'(s_rsp_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) chk($sformatf("vec%0d_rsp_data", i), 32'(s_rsp_data), 32'(tbl[i].e_dat));
    end
    idle_inputs();
    rsp_ready = 1'b1;
    repeat (4) step();

    // Back-to-back reads of 0..7 stream one response per cycle.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(i);
      wr_data  = 16'hA000 + DW'(i);
      step();
    end
    idle_inputs();
    for (int k = 0; k < 11; k++) begin
      rd_valid = (k < 8);
      rd_addr  = AW'(k);
      step();
      v_seen[k] = s_rsp_valid;
      if (k < 8) chk("b2b_rd_ready", 32'(s_rd_ready), 32'(1));
      if (k >= 2 && k < 10) chk("b2b_data", 32'(s_rsp_data), 32'(16'hA000 + DW'(k - 2)));
    end
    for (int k = 0; k < 11; k++) chk("b2b_valid", 32'(v_seen[k]), 32'(k >= 2 && k < 10));
    idle_inputs();

    // Reset with two responses buffered: all discarded, sweep restarts.
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 8'h10; step();
    rd_valid = 1'b1; rd_addr = 8'h20; step();
    rd_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_valid", 32'(s_rsp_valid), 32'(1));
    wr_valid = 1'b1; wr_addr = 8'h33; wr_data = 16'h5555;
    rd_valid = 1'b1; rd_addr = 8'h44;
    do_reset(2);
    idle_inputs();
    rsp_ready = 1'b1;
    repeat (NWORDS) step();
    rd_valid = 1'b1; rd_addr = 8'h10; step();
    rd_valid = 1'b0;
    repeat (3) step();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      wr_valid  = ($urandom_range(0, 99) < 50);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = DW'($urandom);
      rd_valid  = ($urandom_range(0, 99) < 60);
      rd_addr   = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rd_addr = wr_addr;
      rsp_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    idle_inputs();
    rsp_ready = 1'b1;
    repeat (6) step();
    chk("final_drained", 32'(q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
